dcache_store_buffer: RTL and testbench
======================================

Name: dcache_store_buffer

Overview:
- Small FIFO store buffer between the EXE-stage store path (word address, store data, 4-bit byte write enable) and the D-cache write port.
- Decouples committed stores from cache write latency.
- Merges byte writes to the same word at the tail entry.
- Flags loads that hit a pending store word, so the pipeline stalls the load until that store has drained.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous reset, active-high.
- push_valid, input, 1, committed store presented.
- push_ready, output, 1, buffer can accept the store this cycle.
- push_addr, input, 32, store byte address; only [31:2] is stored.
- push_data, input, 32, store data, already lane-aligned.
- push_wen, input, 4, byte write enable.
- cache_req_valid, output, 1, head entry valid toward the D-cache.
- cache_req_ready, input, 1, D-cache accepts the head entry.
- cache_req_addr, output, 32, head word address, {addr[31:2], 2'b00}.
- cache_req_data, output, 32, head data.
- cache_req_wen, output, 4, head byte enable.
- ld_valid, input, 1, load being issued.
- ld_addr, input, 32, load address.
- ld_conflict, output, 1, load word matches a buffered store.
- empty, output, 1, count == 0.
- full, output, 1, count == DEPTH.
- count, output, PTR_W+1, occupied entries.

Behaviour:
- Reset (rst high at posedge): head = tail = 0, count = 0, all entry wen cleared.
  - Outputs after reset: cache_req_valid = 0, ld_conflict = 0, empty = 1, full = 0, push_ready = 1.
  - Reset mid-drain discards all entries; no further cache request is issued.
- Storage: per entry, addr[31:2], data[31:0], wen[3:0]. Registered; all outputs are combinational from registers plus current inputs.
- pop = cache_req_valid && cache_req_ready. Head advances modulo DEPTH.
- cache_req_* reflect the head entry.
  - cache_req_valid = !empty.
  - Payload is held stable while valid && !ready.
- merge_ok = push_valid && count != 0 && push_addr[31:2] == tail_entry.addr && !(count == 1 && pop).
  - tail_entry is entry (tail-1) mod DEPTH.
  - A merge never targets the entry being popped in the same cycle.
- push_ready = !full || merge_ok.
- Accepted push (push_valid && push_ready), priority order:
  - push_wen == 4'b0000: accepted, no state change.
  - merge_ok: for each lane i with push_wen[i], tail_entry.data byte i <= push_data byte i; tail_entry.wen[i] <= 1. Count unchanged by the push.
  - otherwise: new entry written at tail, tail advances modulo DEPTH, count +1.
- Simultaneous push (new entry) and pop: count unchanged. Allowed at full only via merge, since push_ready does not count on the pop.
- Latency: a new entry appears on cache_req one cycle after acceptance when the buffer was empty. No bypass from push to cache_req.
- ld_conflict = ld_valid && there is an occupied entry k with entry[k].addr == ld_addr[31:2] and entry[k].wen != 0.
  - Occupied means k in [head, head+count) modulo DEPTH.
  - A push in the same cycle is not checked; it is visible from the next cycle.
  - The head being popped this cycle still counts as a conflict.
- Wrap-around: pointers wrap at DEPTH.
  - full/empty are derived from count, not from pointer equality.
  - Must hold across at least 2*DEPTH push/pop cycles.
- Write-enable encoding matches store-size rules:
  - SW: 1111.
  - SH: 0011 or 1100.
  - SB: one-hot by addr[1:0].
  - The buffer does not re-check alignment; misaligned stores never reach push_valid.

Test Plan:
- Reset, then SW to 0x1000, data 0xDEADBEEF, wen 1111, cache_req_ready = 1 → cache_req_valid = 1 next cycle with addr 0x1000, wen 1111; empty = 1 the cycle after the pop.
- cache_req_ready = 0; four pushes to 0x00, 0x04, 0x08, 0x0C → full = 1, count = 4. A fifth push to 0x10 sees push_ready = 0. A fifth push to 0x0C with wen 0001 is accepted as a merge.
- SB 0x2000 data 0x000000AA wen 0001, then SB 0x2001 data 0x0000BB00 wen 0010, with ready = 0 → count = 1; head data low 16 bits = 0xBBAA, wen 0011.
- Buffer holds a store to 0x3004; ld_valid with ld_addr 0x3006 → ld_conflict = 1. ld_addr 0x3008 → 0. After the entry pops → 0 for 0x3006.
- count == 1 with pop this cycle, and push to the same word → no merge. A new entry is created, count stays 1, and the popped request carries the old data only.
- Assert rst while count = 3 and cache_req_valid = 1 → next cycle cache_req_valid = 0, count = 0, ld_conflict = 0 for any address. Random push/pop for 3×DEPTH wraps, compared against a reference queue model.

Source files
------------

// File: rtl/dcache_store_buffer_if.sv
// dcache_store_buffer_if: store push, D-cache write request, load conflict and status signals
interface dcache_store_buffer_if #(parameter int DEPTH = 4) ();
  logic push_valid;
  logic push_ready;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic [3:0] push_wen;
  logic cache_req_valid;
  logic cache_req_ready;
  logic [31:0] cache_req_addr;
  logic [31:0] cache_req_data;
  logic [3:0] cache_req_wen;
  logic ld_valid;
  logic [31:0] ld_addr;
  logic ld_conflict;
  logic empty;
  logic full;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output push_valid, push_addr, push_data, push_wen, cache_req_ready, ld_valid, ld_addr,
    input push_ready, cache_req_valid, cache_req_addr, cache_req_data, cache_req_wen,
    input ld_conflict, empty, full, count
  );
  modport slave (
    input push_valid, push_addr, push_data, push_wen, cache_req_ready, ld_valid, ld_addr,
    output push_ready, cache_req_valid, cache_req_addr, cache_req_data, cache_req_wen,
    output ld_conflict, empty, full, count
  );
endinterface

// File: rtl/dcache_store_buffer.sv
// dcache_store_buffer: FIFO of committed word stores toward the D-cache with tail byte merge and load conflict detect
module dcache_store_buffer #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  dcache_store_buffer_if.slave sb
);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
  logic [29:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0] wen_q [DEPTH];
  logic [PTR_W-1:0] head, tail, tail_m1;
  logic [PTR_W:0] cnt;
  logic pop, merge_ok, accept, new_entry, unused_bits;
  logic [DEPTH-1:0] hit;
  assign tail_m1 = tail - 1'b1;
  assign pop = cnt != '0 && sb.cache_req_ready;
  assign merge_ok = sb.push_valid && cnt != '0 && sb.push_addr[31:2] == addr_q[tail_m1] && !(cnt == CNT_ONE && pop);
  assign accept = sb.push_valid && sb.push_ready && sb.push_wen != 4'b0000;
  assign new_entry = accept && !merge_ok;
  assign sb.push_ready = cnt != CNT_MAX || merge_ok;
  assign sb.cache_req_valid = cnt != '0;
  assign sb.cache_req_addr = {addr_q[head], 2'b00};
  assign sb.cache_req_data = data_q[head];
  assign sb.cache_req_wen = wen_q[head];
  assign sb.empty = cnt == '0;
  assign sb.full = cnt == CNT_MAX;
  assign sb.count = cnt;
  assign sb.ld_conflict = sb.ld_valid && |hit;
  assign unused_bits = ^{sb.push_addr[1:0], sb.ld_addr[1:0]};
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++)
      hit[i] = {1'b0, PTR_W'(PTR_W'(i) - head)} < cnt && addr_q[i] == sb.ld_addr[31:2] && wen_q[i] != 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) wen_q[i] <= '0;
    end else begin
      if (pop) head <= head + 1'b1;
      if (new_entry) begin
        addr_q[tail] <= sb.push_addr[31:2];
        data_q[tail] <= sb.push_data;
        wen_q[tail] <= sb.push_wen;
        tail <= tail + 1'b1;
      end else if (accept) begin
        for (int i = 0; i < 4; i++)
          if (sb.push_wen[i]) data_q[tail_m1][8*i +: 8] <= sb.push_data[8*i +: 8];
        wen_q[tail_m1] <= wen_q[tail_m1] | sb.push_wen;
      end
      cnt <= (new_entry && !pop) ? cnt + 1'b1 : (!new_entry && pop) ? cnt - 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_dcache_store_buffer.sv
// tb_dcache_store_buffer: directed and random stimulus checked against a queue model of the store buffer
module tb_dcache_store_buffer;
  localparam int DEPTH = 4;
  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0] w;
  } ent_t;
  logic clk = 0;
  logic rst = 1;
  int n_tests = 0;
  int n_fail = 0;
  bit armed = 0;
  ent_t q[$];
  logic [3:0] wen_list [8] = '{4'hf, 4'h3, 4'hc, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  dcache_store_buffer_if #(.DEPTH(DEPTH)) sb ();
  dcache_store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .sb(sb));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    sb.push_valid = 1;
    sb.push_addr = a;
    sb.push_data = d;
    sb.push_wen = w;
  endtask
  always @(negedge clk) begin
    logic v, pop, mrg, conf;
    int n;
    ent_t e;
    n = q.size();
    v = n != 0;
    pop = v && sb.cache_req_ready;
    mrg = sb.push_valid && v && sb.push_addr[31:2] == q[n-1].a && !(n == 1 && pop);
    conf = 0;
    foreach (q[i]) if (sb.ld_valid && q[i].a == sb.ld_addr[31:2] && q[i].w != 0) conf = 1;
    if (armed) begin
      chk("m_valid", {31'b0, sb.cache_req_valid}, {31'b0, v});
      chk("m_count", {29'b0, sb.count}, n);
      chk("m_empty", {31'b0, sb.empty}, {31'b0, n == 0});
      chk("m_full", {31'b0, sb.full}, {31'b0, n == DEPTH});
      chk("m_push_ready", {31'b0, sb.push_ready}, {31'b0, n != DEPTH || mrg});
      chk("m_ld_conflict", {31'b0, sb.ld_conflict}, {31'b0, conf});
      if (v) begin
        chk("m_req_addr", sb.cache_req_addr, {q[0].a, 2'b00});
        chk("m_req_data", sb.cache_req_data, q[0].d);
        chk("m_req_wen", {28'b0, sb.cache_req_wen}, {28'b0, q[0].w});
      end
    end
    if (rst) begin
      q.delete();
      armed = 1;
    end else if (armed) begin
      if (sb.push_valid && (n != DEPTH || mrg) && sb.push_wen != 0) begin
        if (mrg) begin
          e = q[n-1];
          for (int b = 0; b < 4; b++) if (sb.push_wen[b]) e.d[8*b +: 8] = sb.push_data[8*b +: 8];
          e.w = e.w | sb.push_wen;
          q[n-1] = e;
        end else begin
          e.a = sb.push_addr[31:2];
          e.d = sb.push_data;
          e.w = sb.push_wen;
          q.push_back(e);
        end
      end
      if (pop) void'(q.pop_front());
    end
  end
  initial begin
    sb.push_valid = 0;
    sb.push_addr = 0;
    sb.push_data = 0;
    sb.push_wen = 0;
    sb.cache_req_ready = 0;
    sb.ld_valid = 0;
    sb.ld_addr = 0;
    tick();
    tick();
    rst = 0;
    sb.ld_valid = 1;
    @(negedge clk);
    chk("rst_valid", {31'b0, sb.cache_req_valid}, 0);
    chk("rst_empty", {31'b0, sb.empty}, 1);
    chk("rst_full", {31'b0, sb.full}, 0);
    chk("rst_push_ready", {31'b0, sb.push_ready}, 1);
    chk("rst_conflict", {31'b0, sb.ld_conflict}, 0);
    sb.ld_valid = 0;
    tick();
    sb.cache_req_ready = 1;
    push(32'h1000, 32'hDEADBEEF, 4'hf);
    tick();
    sb.push_valid = 0;
    @(negedge clk);
    chk("sw_valid", {31'b0, sb.cache_req_valid}, 1);
    chk("sw_addr", sb.cache_req_addr, 32'h1000);
    chk("sw_data", sb.cache_req_data, 32'hDEADBEEF);
    chk("sw_wen", {28'b0, sb.cache_req_wen}, 32'hf);
    tick();
    @(negedge clk);
    chk("sw_empty_after_pop", {31'b0, sb.empty}, 1);
    tick();
    sb.cache_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      push(4 * i, 32'hA0A0A0A0 + i, 4'hf);
      tick();
    end
    push(32'h10, 32'h0, 4'hf);
    @(negedge clk);
    chk("fill_full", {31'b0, sb.full}, 1);
    chk("fill_count", {29'b0, sb.count}, 4);
    chk("fill_push_ready_new", {31'b0, sb.push_ready}, 0);
    tick();
    push(32'h0C, 32'h55, 4'h1);
    @(negedge clk);
    chk("fill_push_ready_merge", {31'b0, sb.push_ready}, 1);
    tick();
    sb.push_valid = 0;
    sb.cache_req_ready = 1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("merge_full_addr", sb.cache_req_addr, 32'h0C);
    chk("merge_full_data", sb.cache_req_data, 32'hA0A0A055);
    chk("merge_full_count", {29'b0, sb.count}, 1);
    tick();
    sb.cache_req_ready = 0;
    @(negedge clk);
    chk("drain_empty", {31'b0, sb.empty}, 1);
    push(32'h2000, 32'h000000AA, 4'h1);
    tick();
    push(32'h2001, 32'h0000BB00, 4'h2);
    tick();
    sb.push_valid = 0;
    @(negedge clk);
    chk("sb_count", {29'b0, sb.count}, 1);
    chk("sb_data_lo", {16'b0, sb.cache_req_data[15:0]}, 32'hBBAA);
    chk("sb_wen", {28'b0, sb.cache_req_wen}, 32'h3);
    chk("sb_addr", sb.cache_req_addr, 32'h2000);
    sb.cache_req_ready = 1;
    tick();
    sb.cache_req_ready = 0;
    push(32'h3004, 32'h1, 4'hf);
    tick();
    sb.push_valid = 0;
    sb.ld_valid = 1;
    sb.ld_addr = 32'h3006;
    @(negedge clk);
    chk("ld_hit", {31'b0, sb.ld_conflict}, 1);
    tick();
    sb.ld_addr = 32'h3008;
    @(negedge clk);
    chk("ld_miss", {31'b0, sb.ld_conflict}, 0);
    tick();
    sb.ld_addr = 32'h3006;
    sb.cache_req_ready = 1;
    @(negedge clk);
    chk("ld_hit_popping", {31'b0, sb.ld_conflict}, 1);
    tick();
    sb.cache_req_ready = 0;
    @(negedge clk);
    chk("ld_after_pop", {31'b0, sb.ld_conflict}, 0);
    tick();
    sb.ld_valid = 0;
    push(32'h4000, 32'h11111111, 4'hf);
    tick();
    sb.cache_req_ready = 1;
    push(32'h4000, 32'h22222222, 4'hf);
    @(negedge clk);
    chk("nomerge_pop_data", sb.cache_req_data, 32'h11111111);
    tick();
    sb.push_valid = 0;
    sb.cache_req_ready = 0;
    @(negedge clk);
    chk("nomerge_count", {29'b0, sb.count}, 1);
    chk("nomerge_new_data", sb.cache_req_data, 32'h22222222);
    sb.cache_req_ready = 1;
    tick();
    sb.cache_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      push(32'h6000 + 4 * i, 32'h600 + i, 4'hf);
      tick();
    end
    sb.push_valid = 0;
    sb.ld_valid = 1;
    sb.ld_addr = 32'h6004;
    @(negedge clk);
    chk("prerst_count", {29'b0, sb.count}, 3);
    chk("prerst_conflict", {31'b0, sb.ld_conflict}, 1);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("midrst_valid", {31'b0, sb.cache_req_valid}, 0);
    chk("midrst_count", {29'b0, sb.count}, 0);
    chk("midrst_conflict", {31'b0, sb.ld_conflict}, 0);
    for (int c = 0; c < 200; c++) begin
      tick();
      sb.push_valid = $urandom_range(0, 3) != 0;
      sb.push_addr = 32'h5000 + 4 * $urandom_range(0, 2) + $urandom_range(0, 3);
      sb.push_data = $urandom;
      sb.push_wen = wen_list[$urandom_range(0, 7)];
      sb.cache_req_ready = $urandom_range(0, 2) == 0;
      sb.ld_valid = $urandom_range(0, 1);
      sb.ld_addr = 32'h5000 + 4 * $urandom_range(0, 3);
    end
    tick();
    sb.push_valid = 0;
    sb.cache_req_ready = 1;
    for (int c = 0; c < DEPTH + 2; c++) tick();
    @(negedge clk);
    chk("final_empty", {31'b0, sb.empty}, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
